mem_line_ctrl: RTL and testbench

Cache-line memory controller between the instruction/data cache miss ports and the word-organised line RAM. Arbitrates one outstanding line request at a time from the two caches and converts byte addresses to line-aligned RAM word addresses. Drives the RAM's registered, single-port line interface (read enable, byte strobes) and returns read data or a write acknowledge to the requester. Blocks new traffic while the UART programmer owns the RAM.

---
 rtl/ceres_param.sv | 21 ++
 rtl/mem_rr_arbiter.sv | 40 ++++
 rtl/mem_line_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceres_param.sv
// Shared parameters and types for the memory subsystem.
// Holds the cache line width and the enums used by the line controller.
package ceres_param;

  localparam int unsigned BLK_SIZE = 128;

  // Line controller transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_ctrl_state_e;

  // Requester identity
  typedef enum logic {
    PORT_IC = 1'b0,
    PORT_DC = 1'b1
  } mem_port_e;

endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-requester grant (icache / dcache) with a 1-bit priority pointer.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   rr_en_i            1 = round-robin, 0 = fixed priority (dcache wins)
//   ic_req_i, dc_req_i request inputs
//   advance_i          a grant was taken this cycle; flips the pointer
//   ic_gnt_c, dc_gnt_c combinational one-hot grants
module mem_rr_arbiter
  import ceres_param::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rr_en_i,
  input  logic ic_req_i,
  input  logic dc_req_i,
  input  logic advance_i,
  output logic ic_gnt_c,
  output logic dc_gnt_c
);

  mem_port_e prio_q;
  logic      dc_wins_c;

  // Pointer favours dcache out of reset and flips after every grant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= PORT_DC;
    end else if (advance_i && rr_en_i) begin
      prio_q <= (prio_q == PORT_DC) ? PORT_IC : PORT_DC;
    end
  end

  // Grant resolution
  always_comb begin
    dc_wins_c = dc_req_i && (!ic_req_i || !rr_en_i || (prio_q == PORT_DC));
    dc_gnt_c  = dc_wins_c;
    ic_gnt_c  = ic_req_i && !dc_wins_c;
  end

endmodule

// File: rtl/mem_line_ctrl.sv
// Cache-line memory controller: arbitrates icache/dcache line requests,
// one outstanding at a time, onto a registered single-port line RAM and
// returns read data or a write acknowledge to the requester.
// Build option: MEM_LINE_CTRL_RR_EN selects round-robin arbitration;
// when undefined the dcache has fixed priority.
// Ports:
//   clk_i, rst_ni                clock, async active-low reset
//   prog_mode_i                  programmer owns RAM, no new grants
//   ic_req_*/ic_rsp_*            icache read request / response
//   dc_req_*/dc_rsp_*            dcache read/write request / response
//   ram_addr_o .. ram_rd_en_o    registered RAM controls
//   ram_rdata_i                  RAM read line
module mem_line_ctrl
  import ceres_param::*;
#(
  parameter int unsigned RAM_DEPTH   = 32768,
  parameter int unsigned BLK_SIZE    = ceres_param::BLK_SIZE,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         prog_mode_i,
  input  logic                         ic_req_valid_i,
  output logic                         ic_req_ready_o,
  input  logic [31:0]                  ic_req_addr_i,
  output logic                         ic_rsp_valid_o,
  output logic [BLK_SIZE-1:0]          ic_rsp_data_o,
  input  logic                         dc_req_valid_i,
  output logic                         dc_req_ready_o,
  input  logic [31:0]                  dc_req_addr_i,
  input  logic                         dc_req_we_i,
  input  logic [BLK_SIZE-1:0]          dc_req_wdata_i,
  input  logic [BLK_SIZE/8-1:0]        dc_req_wstrb_i,
  output logic                         dc_rsp_valid_o,
  output logic [BLK_SIZE-1:0]          dc_rsp_data_o,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr_o,
  output logic [BLK_SIZE-1:0]          ram_wdata_o,
  output logic [BLK_SIZE/8-1:0]        ram_wstrb_o,
  output logic                         ram_rd_en_o,
  input  logic [BLK_SIZE-1:0]          ram_rdata_i
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned SW = BLK_SIZE / 8;
  localparam int unsigned LW = $clog2(BLK_SIZE / 32);
  localparam int unsigned CW = 3;

`ifdef MEM_LINE_CTRL_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  mem_ctrl_state_e state_q, state_d;
  mem_port_e       port_q, port_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [AW-1:0]       ram_addr_d;
  logic [BLK_SIZE-1:0] ram_wdata_d;
  logic [SW-1:0]       ram_wstrb_d;
  logic                ram_rd_en_d;
  logic                ic_rsp_valid_d, dc_rsp_valid_d;
  logic [BLK_SIZE-1:0] ic_rsp_data_d, dc_rsp_data_d;

  logic          grant_ok_c, take_c, ic_gnt_c, dc_gnt_c, dc_wr_c;
  logic [31:0]   sel_addr_c;
  logic [AW-1:0] line_addr_c;
  logic          unused_addr_bits;

  // Grants only from IDLE, never while the programmer owns the RAM or in reset
  assign grant_ok_c     = rst_ni && (state_q == IDLE) && !prog_mode_i;
  assign take_c         = grant_ok_c && (ic_req_valid_i || dc_req_valid_i);
  assign ic_req_ready_o = grant_ok_c && ic_gnt_c;
  assign dc_req_ready_o = grant_ok_c && dc_gnt_c;
  assign dc_wr_c        = dc_gnt_c && dc_req_we_i;

  mem_rr_arbiter u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .rr_en_i   (RR_EN),
    .ic_req_i  (ic_req_valid_i),
    .dc_req_i  (dc_req_valid_i),
    .advance_i (take_c),
    .ic_gnt_c  (ic_gnt_c),
    .dc_gnt_c  (dc_gnt_c)
  );

  // Byte address -> line-aligned word address; upper bits alias
  assign sel_addr_c       = dc_gnt_c ? dc_req_addr_i : ic_req_addr_i;
  assign line_addr_c      = {sel_addr_c[AW+1:LW+2], LW'(0)};
  assign unused_addr_bits = ^{sel_addr_c[31:AW+2], sel_addr_c[LW+1:0]};

  // Next-state and registered-output values
  always_comb begin
    state_d        = state_q;
    port_d         = port_q;
    we_d           = we_q;
    cnt_d          = cnt_q;
    ram_addr_d     = ram_addr_o;
    ram_wdata_d    = ram_wdata_o;
    ram_wstrb_d    = '0;
    ram_rd_en_d    = 1'b0;
    ic_rsp_valid_d = 1'b0;
    dc_rsp_valid_d = 1'b0;
    ic_rsp_data_d  = ic_rsp_data_o;
    dc_rsp_data_d  = dc_rsp_data_o;
    unique case (state_q)
      IDLE: begin
        if (take_c) begin
          state_d    = ISSUE;
          cnt_d      = '0;
          ram_addr_d = line_addr_c;
          port_d     = dc_gnt_c ? PORT_DC : PORT_IC;
          we_d       = dc_wr_c;
          if (dc_gnt_c) begin
            ram_wdata_d = dc_req_wdata_i;
          end
          // RAM strobes are registered so they are seen during ISSUE
          ram_rd_en_d = !dc_wr_c;
          ram_wstrb_d = dc_wr_c ? dc_req_wstrb_i : '0;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d        = RESP;
          dc_rsp_valid_d = 1'b1;
          dc_rsp_data_d  = '0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(RAM_LATENCY - 1)) begin
          state_d = RESP;
          if (port_q == PORT_DC) begin
            dc_rsp_valid_d = 1'b1;
            dc_rsp_data_d  = ram_rdata_i;
          end else begin
            ic_rsp_valid_d = 1'b1;
            ic_rsp_data_d  = ram_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      port_q         <= PORT_IC;
      we_q           <= 1'b0;
      cnt_q          <= '0;
      ram_addr_o     <= '0;
      ram_wdata_o    <= '0;
      ram_wstrb_o    <= '0;
      ram_rd_en_o    <= 1'b0;
      ic_rsp_valid_o <= 1'b0;
      dc_rsp_valid_o <= 1'b0;
      ic_rsp_data_o  <= '0;
      dc_rsp_data_o  <= '0;
    end else begin
      state_q        <= state_d;
      port_q         <= port_d;
      we_q           <= we_d;
      cnt_q          <= cnt_d;
      ram_addr_o     <= ram_addr_d;
      ram_wdata_o    <= ram_wdata_d;
      ram_wstrb_o    <= ram_wstrb_d;
      ram_rd_en_o    <= ram_rd_en_d;
      ic_rsp_valid_o <= ic_rsp_valid_d;
      dc_rsp_valid_o <= dc_rsp_valid_d;
      ic_rsp_data_o  <= ic_rsp_data_d;
      dc_rsp_data_o  <= dc_rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Self-checking bench for mem_line_ctrl: directed scenarios plus randomized
// traffic against a line-level reference model. A second instance with a
// 3-cycle RAM latency covers the longer read path.
module tb_mem_line_ctrl;

  localparam int unsigned RAM_DEPTH = 32768;
  localparam int unsigned LINES     = RAM_DEPTH / 4;
  localparam int unsigned LAT       = 1;
  localparam int unsigned LAT3      = 3;
`ifdef MEM_LINE_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         prog_mode;
  logic         ic_req_valid, ic_req_ready, ic_rsp_valid;
  logic [31:0]  ic_req_addr;
  logic [127:0] ic_rsp_data;
  logic         dc_req_valid, dc_req_ready, dc_req_we, dc_rsp_valid;
  logic [31:0]  dc_req_addr;
  logic [127:0] dc_req_wdata, dc_rsp_data;
  logic [15:0]  dc_req_wstrb;
  logic [14:0]  ram_addr;
  logic [127:0] ram_wdata, ram_rdata;
  logic [15:0]  ram_wstrb;
  logic         ram_rd_en;

  // Latency-3 instance signals (icache traffic only)
  logic         l3_prog, l3_ic_valid, l3_ic_ready, l3_ic_rsp_valid;
  logic [31:0]  l3_ic_addr;
  logic [127:0] l3_ic_rsp_data;
  logic         l3_dc_valid, l3_dc_ready, l3_dc_we, l3_dc_rsp_valid;
  logic [31:0]  l3_dc_addr;
  logic [127:0] l3_dc_wdata, l3_dc_rsp_data;
  logic [15:0]  l3_dc_wstrb;
  logic [14:0]  l3_ram_addr;
  logic [127:0] l3_ram_wdata, l3_ram_rdata;
  logic [15:0]  l3_ram_wstrb;
  logic         l3_ram_rd_en;

  int n_checks = 0;
  int n_errors = 0;
  bit favor_dc = 1'b1;

  always #5 clk_i = ~clk_i;

  mem_line_ctrl #(.RAM_DEPTH(RAM_DEPTH), .BLK_SIZE(128), .RAM_LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .prog_mode_i(prog_mode),
    .ic_req_valid_i(ic_req_valid), .ic_req_ready_o(ic_req_ready), .ic_req_addr_i(ic_req_addr),
    .ic_rsp_valid_o(ic_rsp_valid), .ic_rsp_data_o(ic_rsp_data),
    .dc_req_valid_i(dc_req_valid), .dc_req_ready_o(dc_req_ready), .dc_req_addr_i(dc_req_addr),
    .dc_req_we_i(dc_req_we), .dc_req_wdata_i(dc_req_wdata), .dc_req_wstrb_i(dc_req_wstrb),
    .dc_rsp_valid_o(dc_rsp_valid), .dc_rsp_data_o(dc_rsp_data),
    .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_wstrb_o(ram_wstrb),
    .ram_rd_en_o(ram_rd_en), .ram_rdata_i(ram_rdata)
  );

  mem_line_ctrl #(.RAM_DEPTH(RAM_DEPTH), .BLK_SIZE(128), .RAM_LATENCY(LAT3)) dut_l3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .prog_mode_i(l3_prog),
    .ic_req_valid_i(l3_ic_valid), .ic_req_ready_o(l3_ic_ready), .ic_req_addr_i(l3_ic_addr),
    .ic_rsp_valid_o(l3_ic_rsp_valid), .ic_rsp_data_o(l3_ic_rsp_data),
    .dc_req_valid_i(l3_dc_valid), .dc_req_ready_o(l3_dc_ready), .dc_req_addr_i(l3_dc_addr),
    .dc_req_we_i(l3_dc_we), .dc_req_wdata_i(l3_dc_wdata), .dc_req_wstrb_i(l3_dc_wstrb),
    .dc_rsp_valid_o(l3_dc_rsp_valid), .dc_rsp_data_o(l3_dc_rsp_data),
    .ram_addr_o(l3_ram_addr), .ram_wdata_o(l3_ram_wdata), .ram_wstrb_o(l3_ram_wstrb),
    .ram_rd_en_o(l3_ram_rd_en), .ram_rdata_i(l3_ram_rdata)
  );

  // Initial RAM image; line 1 (words 4..7) holds the known pattern
  function automatic logic [127:0] init_line(input int i);
    if (i == 1) return {32'h44, 32'h33, 32'h22, 32'h11};
    return {32'(i) * 32'h9E3779B1, 32'(i) ^ 32'hA5A5_0000, ~32'(i), 32'(i) * 32'h0101_0101 + 32'h1234};
  endfunction

  // Line RAM with configurable read latency; junk on the pipe when not reading
  logic [127:0] ram    [LINES];
  logic [127:0] golden [LINES];
  logic [127:0] pipe   [8];
  logic [127:0] pipe3  [8];
  bit           ram_loaded = 1'b0;

  assign ram_rdata    = pipe[LAT-1];
  assign l3_ram_rdata = pipe3[LAT3-1];

  always @(posedge clk_i) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(LINES); i++) ram[i] <= init_line(i);
      ram_loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 16; b++)
        if (ram_wstrb[b]) ram[ram_addr[14:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end
    pipe[0]  <= ram_rd_en    ? ram[ram_addr[14:2]]    : {$urandom, $urandom, $urandom, $urandom};
    pipe3[0] <= l3_ram_rd_en ? ram[l3_ram_addr[14:2]] : {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k < 8; k++) begin
      pipe[k]  <= pipe[k-1];
      pipe3[k] <= pipe3[k-1];
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) % LINES);
  endfunction

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFE_0000) | (32'($urandom_range(0, 63)) << 4) | 32'($urandom_range(0, 15));
  endfunction

  // One request/response; called right after a negedge with the DUT idle
  task automatic do_txn(input bit v_ic, input bit v_dc, input logic [31:0] a_ic,
                        input logic [31:0] a_dc, input bit we, input logic [127:0] wd,
                        input logic [15:0] ws);
    bit win_dc, is_wr;
    int k, n, lat, line;
    logic [127:0] exp_data;
    win_dc = v_dc && (!v_ic || !RR || favor_dc);
    ic_req_valid = v_ic; ic_req_addr = a_ic;
    dc_req_valid = v_dc; dc_req_addr = a_dc; dc_req_we = we; dc_req_wdata = wd; dc_req_wstrb = ws;
    #1;
    k = 0;
    while (!(ic_req_ready || dc_req_ready) && k < 8) begin
      @(negedge clk_i); #1; k++;
    end
    check("grant_wait", 128'(k), 128'(0));
    if (k == 8) begin
      ic_req_valid = 1'b0; dc_req_valid = 1'b0;
      return;
    end
    check("ic_ready", 128'(ic_req_ready), 128'(!win_dc));
    check("dc_ready", 128'(dc_req_ready), 128'(win_dc));
    if (RR) favor_dc = !favor_dc;
    line  = line_of(win_dc ? a_dc : a_ic);
    is_wr = win_dc && we;
    if (is_wr) begin
      for (int b = 0; b < 16; b++) if (ws[b]) golden[line][b*8 +: 8] = wd[b*8 +: 8];
      exp_data = '0;
      lat = 2;
    end else begin
      exp_data = golden[line];
      lat = 2 + int'(LAT);
    end
    @(negedge clk_i);
    check("issue_addr", 128'(ram_addr), 128'(line * 4));
    check("issue_rd_en", 128'(ram_rd_en), 128'(!is_wr));
    check("issue_wstrb", 128'(ram_wstrb), is_wr ? 128'(ws) : 128'(0));
    if (is_wr) check("issue_wdata", ram_wdata, wd);
    check("busy_ready", 128'(ic_req_ready | dc_req_ready), 128'(0));
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    n = 1;
    while (!(ic_rsp_valid || dc_rsp_valid) && n < lat + 4) begin
      @(negedge clk_i); n++;
      if (n == 2) check("ram_pulse", 128'({ram_rd_en, ram_wstrb}), 128'(0));
    end
    check("rsp_cycle", 128'(n), 128'(lat));
    check("rsp_dc", 128'(dc_rsp_valid), 128'(win_dc));
    check("rsp_ic", 128'(ic_rsp_valid), 128'(!win_dc));
    check("rsp_data", win_dc ? dc_rsp_data : ic_rsp_data, exp_data);
    @(negedge clk_i);
    check("rsp_pulse", 128'(ic_rsp_valid | dc_rsp_valid), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, n, line;
    bit exp_dc;
    logic [31:0] a;
    logic [127:0] wd;
    logic [15:0] ws;
    rst_ni = 1'b0; prog_mode = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    dc_req_valid = 1'b0; dc_req_addr = '0; dc_req_we = 1'b0; dc_req_wdata = '0; dc_req_wstrb = '0;
    l3_prog = 1'b0; l3_ic_valid = 1'b0; l3_ic_addr = '0;
    l3_dc_valid = 1'b0; l3_dc_addr = '0; l3_dc_we = 1'b0; l3_dc_wdata = '0; l3_dc_wstrb = '0;
    for (int i = 0; i < int'(LINES); i++) golden[i] = init_line(i);

    // Reset values, including ready held low while a request is pending
    repeat (3) @(negedge clk_i);
    dc_req_valid = 1'b1;
    #1;
    check("rst_outputs", 128'({ic_rsp_valid, dc_rsp_valid, ram_rd_en, ram_wstrb, ram_addr}), 128'(0));
    check("rst_ready", 128'({ic_req_ready, dc_req_ready}), 128'(0));
    check("rst_rsp_data", ic_rsp_data | dc_rsp_data | ram_wdata, 128'(0));
    dc_req_valid = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i);

    // Directed: icache read of line 1, dcache write, read-back, aliasing
    do_txn(1'b1, 1'b0, 32'h0000_0014, '0, 1'b0, '0, '0);
    do_txn(1'b0, 1'b1, '0, 32'h0000_0100, 1'b1, {96'h0, 32'hDEADBEEF}, 16'h000F);
    do_txn(1'b0, 1'b1, '0, 32'h0000_0100, 1'b0, '0, '0);
    do_txn(1'b1, 1'b0, 32'hFFFE_0014, '0, 1'b0, '0, '0);
    // Zero strobe write leaves the line unchanged but is acknowledged
    do_txn(1'b0, 1'b1, '0, 32'h0000_0200, 1'b1, {4{$urandom}}, 16'h0000);
    do_txn(1'b1, 1'b0, 32'h0000_0208, '0, 1'b0, '0, '0);

    // Both ports requesting continuously for four grants
    ic_req_valid = 1'b1; ic_req_addr = 32'h40;
    dc_req_valid = 1'b1; dc_req_addr = 32'h80; dc_req_we = 1'b0;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      #1;
      while (!(ic_req_ready || dc_req_ready) && k < 12) begin
        @(negedge clk_i); #1; k++;
      end
      exp_dc = !RR || favor_dc;
      check("contend_dc", 128'(dc_req_ready), 128'(exp_dc));
      check("contend_ic", 128'(ic_req_ready), 128'(!exp_dc));
      if (RR) favor_dc = !favor_dc;
      @(negedge clk_i);
    end
    ic_req_valid = 1'b0; dc_req_valid = 1'b0;
    repeat (4) @(negedge clk_i);

    // Programmer takes the RAM while a read is waiting on data
    ic_req_valid = 1'b1; ic_req_addr = 32'h30;
    #1;
    check("prog_grant", 128'(ic_req_ready), 128'(1));
    if (RR) favor_dc = !favor_dc;
    @(negedge clk_i); ic_req_valid = 1'b0;
    @(negedge clk_i); prog_mode = 1'b1;
    dc_req_valid = 1'b1; dc_req_addr = 32'h50; dc_req_we = 1'b0;
    @(negedge clk_i);
    check("prog_rsp_valid", 128'(ic_rsp_valid), 128'(1));
    check("prog_rsp_data", ic_rsp_data, golden[3]);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      check("prog_block", 128'(dc_req_ready), 128'(0));
    end
    @(negedge clk_i); prog_mode = 1'b0;
    #1;
    check("prog_release", 128'(dc_req_ready), 128'(1));
    dc_req_valid = 1'b0;
    @(negedge clk_i);

    // Reset while a read is in WAIT: everything clears, no late response
    ic_req_valid = 1'b1; ic_req_addr = 32'h70;
    #1;
    check("rstw_grant", 128'(ic_req_ready), 128'(1));
    @(negedge clk_i); ic_req_valid = 1'b0;
    @(negedge clk_i); rst_ni = 1'b0; dc_req_valid = 1'b1;
    #1;
    check("rstw_outputs", 128'({ic_rsp_valid, dc_rsp_valid, ram_rd_en, ram_wstrb, ram_addr}), 128'(0));
    check("rstw_ready", 128'({ic_req_ready, dc_req_ready}), 128'(0));
    check("rstw_data", ic_rsp_data | dc_rsp_data | ram_wdata, 128'(0));
    favor_dc = 1'b1;
    @(negedge clk_i); dc_req_valid = 1'b0;
    @(negedge clk_i); rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("rstw_no_rsp", 128'(ic_rsp_valid | dc_rsp_valid), 128'(0));
    end
    do_txn(1'b1, 1'b0, 32'h70, '0, 1'b0, '0, '0);

    // Randomized mixed traffic
    for (int i = 0; i < 40; i++) begin
      n  = $urandom_range(0, 2);
      ws = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      do_txn(n != 1, n != 0, rand_addr(), rand_addr(), 1'($urandom), wd, ws);
    end

    // Longer RAM latency: response three cycles later
    for (int r = 0; r < 3; r++) begin
      a = (r == 0) ? 32'h0000_0014 : rand_addr();
      line = line_of(a);
      l3_ic_valid = 1'b1; l3_ic_addr = a;
      #1;
      check("l3_ready", 128'(l3_ic_ready), 128'(1));
      @(negedge clk_i); l3_ic_valid = 1'b0;
      n = 1;
      while (!l3_ic_rsp_valid && n < 12) begin
        @(negedge clk_i); n++;
      end
      check("l3_rsp_cycle", 128'(n), 128'(2 + LAT3));
      check("l3_rsp_data", l3_ic_rsp_data, golden[line]);
      @(negedge clk_i);
    end
    check("l3_dc_idle", 128'({l3_dc_ready, l3_dc_rsp_valid, l3_ram_wstrb}), 128'(0));
    check("l3_dc_data", l3_dc_rsp_data | l3_ram_wdata, 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
